uio_bus_sched: RTL

Arbiter and direction controller for the shared 8-bit bidirectional uio pad bus of the top-level tile. Up to NREQ internal requesters ask for the bus as either writer (drives pads) or reader (samples pads). The block grants one owner at a time round-robin and inserts turnaround cycles with all pads tri-stated between owners. It drives uio_out/uio_oe directly and returns registered pad data to readers.

---
 rtl/uio_bus_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uio_bus_sched.sv
// uio_bus_sched: round-robin owner arbitration for the shared 8-bit uio pad bus,
// with tri-stated turnaround cycles between owners and a registered read path.
module uio_bus_sched #(
  parameter int NREQ     = 4,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     wr,
  input  logic [8*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]     gnt,
  input  logic [7:0]          uio_in,
  output logic [7:0]          uio_out,
  output logic [7:0]          uio_oe,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_OWN  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [IW-1:0]   r_win, w_win_nxt;
  logic [IW-1:0]   w_win_inc, w_arb_ptr, w_arb_idx;
  logic            r_wr_lat, w_wr_lat_nxt;
  logic [3:0]      r_turn_cnt, w_turn_nxt;
  logic [7:0]      r_hold, w_hold_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] w_win_oh, w_arb_cand;
  logic [7:0]      r_uio_out, w_uio_out_nxt;
  logic [7:0]      r_uio_oe, w_uio_oe_nxt;
  logic [7:0]      r_rd_data, w_rd_data_nxt;
  logic            r_rd_valid, w_rd_valid_nxt;
  logic            w_arb_found, w_release, w_own_nxt;
  logic [7:0]      w_wdata_sel;
  int              w_scan;

  // Request/grant contract: req[i] is a level held for as long as requester i
  // wants the pads; gnt[i] is high exactly in the cycles i owns them, and
  // ownership ends the cycle after req[i] is seen low or the hold limit is hit
  // while someone else is waiting. There is no other acknowledgement.
  assign w_win_oh  = NREQ'(1) << r_win;
  assign w_win_inc = (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);
  assign w_release = (r_state == S_OWN) &&
                     (!req[r_win] ||
                      ((r_hold == 8'(MAX_HOLD)) && (|(req & ~w_win_oh))));

  // On release the search starts past the outgoing owner and excludes it.
  assign w_arb_ptr  = (r_state == S_OWN) ? w_win_inc : r_ptr;
  assign w_arb_cand = ena ? (req & ~((r_state == S_OWN) ? w_win_oh : '0)) : '0;

  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_scan      = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = int'(w_arb_ptr) + k;
      if (w_scan >= NREQ) w_scan = w_scan - NREQ;
      if (!w_arb_found && w_arb_cand[IW'(w_scan)]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = IW'(w_scan);
      end
    end
  end

  always_comb begin
    w_wdata_sel = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      if (r_win == IW'(k)) w_wdata_sel = wdata[8*k +: 8];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_win      <= '0;
      r_wr_lat   <= 1'b0;
      r_turn_cnt <= '0;
      r_hold     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_win      <= w_win_nxt;
      r_wr_lat   <= w_wr_lat_nxt;
      r_turn_cnt <= w_turn_nxt;
      r_hold     <= w_hold_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_win_nxt    = r_win;
    w_wr_lat_nxt = r_wr_lat;
    w_turn_nxt   = r_turn_cnt;
    w_hold_nxt   = r_hold;
    case (r_state)
      S_IDLE: begin
        if (w_arb_found) begin
          w_state_nxt  = S_TURN;
          w_win_nxt    = w_arb_idx;
          w_wr_lat_nxt = wr[w_arb_idx];
          w_turn_nxt   = 4'(TURN_CYC);
        end
      end
      S_TURN: begin
        if (r_turn_cnt <= 4'd1) begin
          w_state_nxt = S_OWN;
          w_turn_nxt  = '0;
          w_hold_nxt  = 8'd1;
        end else begin
          w_turn_nxt = r_turn_cnt - 4'd1;
        end
      end
      S_OWN: begin
        if (w_release) begin
          w_ptr_nxt  = w_win_inc;
          w_hold_nxt = '0;
          if (w_arb_found) begin
            w_state_nxt  = S_TURN;
            w_win_nxt    = w_arb_idx;
            w_wr_lat_nxt = wr[w_arb_idx];
            w_turn_nxt   = 4'(TURN_CYC);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (r_hold != 8'(MAX_HOLD)) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: values the pad/grant registers take at the next edge
  always_comb begin
    w_own_nxt      = (w_state_nxt == S_OWN);
    w_gnt_nxt      = w_own_nxt ? (NREQ'(1) << w_win_nxt) : '0;
    w_uio_oe_nxt   = (w_own_nxt && w_wr_lat_nxt) ? 8'hFF : 8'h00;
    w_uio_out_nxt  = (w_own_nxt && w_wr_lat_nxt) ? w_wdata_sel : 8'h00;
    w_rd_valid_nxt = (r_state == S_OWN) && !r_wr_lat;
    w_rd_data_nxt  = w_rd_valid_nxt ? uio_in : r_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt      <= '0;
      r_uio_out  <= 8'h00;
      r_uio_oe   <= 8'h00;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
    end else begin
      r_gnt      <= w_gnt_nxt;
      r_uio_out  <= w_uio_out_nxt;
      r_uio_oe   <= w_uio_oe_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign uio_out   = r_uio_out;
  assign uio_oe    = r_uio_oe;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(r_gnt));
  a_oe_owner: assert property (@(posedge clk) disable iff (!rst_n)
    (r_uio_oe != 8'h00) |-> ((r_state == S_OWN) && r_wr_lat));

endmodule
